// File: rtl/enc_ctrl_multi.sv
// enc_ctrl_multi: N-channel quadrature encoder controller.
// Per channel: sync + debounce, 4x decode into a preloadable counter,
// illegal-transition counting and a direction-tagged edge period.
// Optional index capture is built only when ENC_INDEX_EN is defined.

module enc_ctrl_deb #(
  parameter int W       = 1,
  parameter int DEB_CYC = 8
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] sync1, sync2;
  logic [7:0]   run [W];

  // Two-flop synchroniser, then accept a new level after DEB_CYC equal samples.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      dout  <= '0;
      for (int unsigned i = 0; i < W; i++) run[i] <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      for (int unsigned i = 0; i < W; i++) begin
        if (sync2[i] == dout[i]) begin
          run[i] <= '0;
        end else if (run[i] == 8'(DEB_CYC - 1)) begin
          dout[i] <= sync2[i];
          run[i]  <= '0;
        end else begin
          run[i] <= run[i] + 8'd1;
        end
      end
    end
  end
endmodule

module enc_ctrl_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int PER_W   = 22,
  parameter int DEB_CYC = 8,
  parameter int DIV_W   = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  input  logic [NUM_CH-1:0] enc_idx,
  input  logic [15:0]       reg_raddr,
  output logic [31:0]       reg_rdata,
  input  logic [15:0]       reg_waddr,
  input  logic [31:0]       reg_wdata,
  input  logic              reg_wen,
  output logic [NUM_CH-1:0] enc_dir
);
  localparam logic [CNT_W-1:0] CNT_MID = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [PER_W-1:0] PER_MAX = '1;

  logic [NUM_CH-1:0] fa, fb;
  logic [NUM_CH-1:0] step, dbl, up, wr_hit, ovf, per_sat;
  logic [1:0]        prev_ab [NUM_CH];
  logic [CNT_W-1:0]  count   [NUM_CH];
  logic [CNT_W-1:0]  preload [NUM_CH];
  logic [7:0]        err     [NUM_CH];
  logic [PER_W-1:0]  per_cnt [NUM_CH];
  logic [PER_W-1:0]  per_nxt [NUM_CH];
  logic [PER_W-1:0]  per_val [NUM_CH];
  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [31:0]       rd_word;

  enc_ctrl_deb #(.W(2 * NUM_CH), .DEB_CYC(DEB_CYC)) u_deb_ab (
    .sysclk (sysclk),
    .reset  (reset),
    .din    ({enc_a, enc_b}),
    .dout   ({fa, fb})
  );

  assign tick = &div;

  // Transition classification, period-at-edge value and write decode per channel.
  always_comb begin
    step   = '0;
    dbl    = '0;
    up     = '0;
    wr_hit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      step[c]   = (fa[c] ^ prev_ab[c][1]) != (fb[c] ^ prev_ab[c][0]);
      dbl[c]    = (fa[c] ^ prev_ab[c][1]) & (fb[c] ^ prev_ab[c][0]);
      up[c]     = prev_ab[c][1] ^ fb[c];
      wr_hit[c] = reg_wen && (reg_waddr[15:12] == 4'h0) &&
                  (reg_waddr[7:4] == 4'(c + 1)) && (reg_waddr[3:0] == 4'h0);
      // The tick of the edge cycle belongs to the interval that ends there.
      per_nxt[c] = (tick && per_cnt[c] != PER_MAX) ? per_cnt[c] + PER_W'(1) : per_cnt[c];
    end
  end

  // Counter, flags and period state; a preload write overrides a same-cycle edge.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      div     <= '0;
      enc_dir <= '0;
      ovf     <= '0;
      per_sat <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        prev_ab[c] <= '0;
        count[c]   <= CNT_MID;
        preload[c] <= CNT_MID;
        err[c]     <= '0;
        per_cnt[c] <= '0;
        per_val[c] <= '0;
      end
    end else begin
      div <= div + DIV_W'(1);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        prev_ab[c] <= {fa[c], fb[c]};
        if (wr_hit[c]) begin
          preload[c] <= reg_wdata[CNT_W-1:0];
          count[c]   <= reg_wdata[CNT_W-1:0];
          ovf[c]     <= 1'b0;
          err[c]     <= '0;
        end else if (step[c]) begin
          count[c]   <= up[c] ? count[c] + CNT_W'(1) : count[c] - CNT_W'(1);
          if (up[c] ? &count[c] : ~|count[c]) ovf[c] <= 1'b1;
          enc_dir[c] <= up[c];
        end else if (dbl[c] && err[c] != 8'hFF) begin
          err[c] <= err[c] + 8'd1;
        end

        if (step[c] && !wr_hit[c]) begin
          per_cnt[c] <= '0;
          if (up[c] != enc_dir[c]) begin
            per_val[c] <= PER_MAX;
            per_sat[c] <= 1'b1;
          end else begin
            per_val[c] <= per_nxt[c];
            per_sat[c] <= (per_nxt[c] == PER_MAX);
          end
        end else if (per_cnt[c] == PER_MAX) begin
          // No edge for a full period range: publish the saturated value.
          per_val[c] <= PER_MAX;
          per_sat[c] <= 1'b1;
        end else if (tick) begin
          per_cnt[c] <= per_cnt[c] + PER_W'(1);
        end
      end
    end
  end

`ifdef ENC_INDEX_EN
  logic [NUM_CH-1:0] fidx, fidx_q, idx_seen, rd_clr;
  logic [CNT_W-1:0]  idx_cnt [NUM_CH];

  enc_ctrl_deb #(.W(NUM_CH), .DEB_CYC(DEB_CYC)) u_deb_idx (
    .sysclk (sysclk),
    .reset  (reset),
    .din    (enc_idx),
    .dout   (fidx)
  );

  // Index capture on filtered rising edge; a read of offset 3 clears the seen flag.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      fidx_q   <= '0;
      idx_seen <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) idx_cnt[c] <= '0;
    end else begin
      fidx_q <= fidx;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (fidx[c] && !fidx_q[c]) begin
          idx_cnt[c]  <= count[c];
          idx_seen[c] <= 1'b1;
        end else if (rd_clr[c]) begin
          idx_seen[c] <= 1'b0;
        end
      end
    end
  end
`endif

  // Read word selection by channel and offset.
  always_comb begin
    rd_word = '0;
`ifdef ENC_INDEX_EN
    rd_clr  = '0;
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (reg_raddr[15:12] == 4'h0 && reg_raddr[7:4] == 4'(c + 1)) begin
        case (reg_raddr[3:0])
          4'h0: rd_word[CNT_W-1:0] = preload[c];
          4'h1: rd_word[CNT_W:0]   = {ovf[c], count[c]};
          4'h2: begin
            rd_word[31]         = enc_dir[c];
            rd_word[30]         = per_sat[c];
            rd_word[PER_W-1:0]  = per_val[c];
          end
`ifdef ENC_INDEX_EN
          4'h3: begin
            rd_word[31]         = idx_seen[c];
            rd_word[CNT_W-1:0]  = idx_cnt[c];
            rd_clr[c]           = 1'b1;
          end
`endif
          4'h4: rd_word[7:0] = err[c];
          default: ;
        endcase
      end
    end
  end

  // Registered read data.
  always_ff @(posedge sysclk) begin
    if (reset) reg_rdata <= '0;
    else       reg_rdata <= rd_word;
  end

  logic unused_bits;
`ifdef ENC_INDEX_EN
  assign unused_bits = ^{reg_raddr[11:8], reg_waddr[11:8], reg_wdata[31:CNT_W]};
`else
  assign unused_bits = ^{reg_raddr[11:8], reg_waddr[11:8], reg_wdata[31:CNT_W], enc_idx};
`endif

endmodule
